mips_alu_hilo_unit: RTL and testbench
=====================================

// Module: mips_alu_hilo_unit
// PURPOSE
//  Sequential HI/LO owner for the MIPS EX stage: accepts mult/div/mthi/mtlo ops, runs
//  iterative shift-add multiply and restoring divide, holds HI/LO, drives reg_lo/reg_hi
//  back to the ALU. Asserts busy so hazard logic stalls mflo/mfhi and new HI/LO ops.
// PARAMETERS
//  DATA_W   32                      operand / HI / LO width
//  CNT_W    Util_Math_log2(DATA_W)+1 iteration counter width
// PORTS
//  clk      in   1              clock, rising edge
//  rst      in   1              asynchronous, active-high reset
//  start    in   1              op request; accepted only when busy==0
//  func     in   Mips_Alu_Func_T  Muls/Mulu/Divs/Divu/Mthi/Mtlo; other codes ignored
//  data1    in   DATA_W         rs operand (multiplicand/dividend/mt source)
//  data2    in   DATA_W         rt operand (multiplier/divisor)
//  cancel   in   1              abort in-flight op (branch flush/exception)
//  busy     out  1              iterative op in flight
//  done     out  1              1-cycle pulse, HI/LO updated this edge
//  reg_lo   out  DATA_W         LO register
//  reg_hi   out  DATA_W         HI register
// BEHAVIOUR
//  - Reset (async): reg_lo=reg_hi=0, busy=0, done=0, FSM=IDLE, counter=0, temporaries=0.
//  - FSM IDLE -> RUN -> FIX -> IDLE. Accept = start & ~busy & func in op set.
//  - Mtlo/Mthi accepted in IDLE: LO/HI <= data1 at that edge; done=1 next cycle; no busy.
//  - Mul/Div accepted in IDLE: latch |a|,|b| (signed ops) or raw (unsigned), record
//    result signs, counter<=DATA_W, go RUN. busy=1 from next cycle.
//  - RUN: one step/cycle (shift-add mul over 2*DATA_W product; restoring div step);
//    counter decrements; at counter==1 go FIX. FIX: sign-correct, write HI/LO, done=1, busy=0.
//  - Latency: accept at cycle 0; busy high cycles 1..DATA_W+1; HI/LO valid cycle DATA_W+2.
//  - Mul: {HI,LO}=full 2*DATA_W product; signed product negated if operand signs differ.
//  - Div: LO=quotient trunc toward zero, HI=remainder with dividend's sign.
//  - Signed INT_MIN / -1: LO=INT_MIN, HI=0 (wrap, no trap).
//  - Div by zero: HI=data1; unsigned LO=all-ones; signed LO=all-ones if data1>=0 else 1.
//  - start while busy: ignored (hazard logic guarantees stall); HI/LO unchanged until FIX.
//  - cancel in RUN/FIX: FSM->IDLE next edge, busy=0, HI/LO keep pre-op values, no done.
//    cancel same cycle as start in IDLE: start wins (flush applies to later instr only).
//  - reg_lo/reg_hi never change except at Mt write, FIX write, or reset.
// CONFIGURATION
//  MIPS_ALU_HILO_FAST_MUL_EN defined: Muls/Mulu done in accept cycle via single '*'
//   (signed or unsigned); HI/LO written at accept edge, done next cycle, busy never set.
//   Divide unchanged (iterative).
//  Undefined: multiply iterative as above (DATA_W+1 busy cycles), no '*' operator.
// STRUCTURE
//  - Shared include Mips/Alu/HiLo.v: FSM state macros (IDLE/RUN/FIX), state width,
//    op-class decode macros (is_mul/is_div/is_signed/is_mt) built on Mips/Alu/Func.v codes.
//  - Sub-module mips_alu_hilo_step: combinational single step (mul shift-add or div
//    restoring compare/subtract), selected by mode input; instantiated once.
//  - Top holds FSM, counter, operand/accumulator regs, sign fix, HI/LO regs.
// TESTING
//  1 Mulu 0xFFFFFFFF*0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse.
//  2 Muls -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; with FAST_MUL_EN same values, busy stays 0.
//  3 Divs -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; Divs 0x80000000/-1 -> LO=0x80000000, HI=0.
//  4 Divu 5/0 -> LO=0xFFFFFFFF, HI=5; Divs -5/0 -> LO=1, HI=0xFFFFFFFB.
//  5 HI=LO=0x1234 via Mthi/Mtlo, start Divu 100/7, cancel at busy cycle 10 -> busy=0 next
//    cycle, no done, HI=LO=0x1234; start during busy ignored.
//  6 rst asserted mid-Divu (cycle 5, async, between edges) -> HI=LO=0, busy=0 immediately;
//    new Mtlo after release writes normally.

Source files
------------

// File: rtl/mips_alu_hilo_unit_pkg.sv
// ============================================================================
// mips_alu_hilo_unit_pkg : ALU function codes, HI/LO FSM states, op-class decode
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_alu_hilo_unit_pkg;

  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_SUB  = 4'd1,
    FUNC_AND  = 4'd2,
    FUNC_OR   = 4'd3,
    FUNC_XOR  = 4'd4,
    FUNC_SLT  = 4'd5,
    FUNC_MULS = 4'd8,
    FUNC_MULU = 4'd9,
    FUNC_DIVS = 4'd10,
    FUNC_DIVU = 4'd11,
    FUNC_MTHI = 4'd12,
    FUNC_MTLO = 4'd13
  } mips_alu_func_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } hilo_state_t;

  function automatic logic is_mul(input mips_alu_func_t f);
    return (f == FUNC_MULS) || (f == FUNC_MULU);
  endfunction

  function automatic logic is_div(input mips_alu_func_t f);
    return (f == FUNC_DIVS) || (f == FUNC_DIVU);
  endfunction

  function automatic logic is_signed_op(input mips_alu_func_t f);
    return (f == FUNC_MULS) || (f == FUNC_DIVS);
  endfunction

  function automatic logic is_mt(input mips_alu_func_t f);
    return (f == FUNC_MTHI) || (f == FUNC_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_alu_hilo_unit_step.sv
// ============================================================================
// mips_alu_hilo_unit_step : one combinational iteration of shift-add multiply
// or restoring divide over the {acc_hi, acc_lo} register pair.
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_alu_hilo_unit_step
  import mips_alu_hilo_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_div,
  input  logic [DATA_W-1:0] i_acc_hi,
  input  logic [DATA_W-1:0] i_acc_lo,
  input  logic [DATA_W-1:0] i_opnd,
  output logic [DATA_W-1:0] o_acc_hi,
  output logic [DATA_W-1:0] o_acc_lo
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc_hi} + {1'b0, (i_acc_lo[0] ? i_opnd : {DATA_W{1'b0}})};
    w_shift = {i_acc_hi, i_acc_lo[DATA_W-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    o_acc_hi = w_sum[DATA_W:1];
    o_acc_lo = {w_sum[0], i_acc_lo[DATA_W-1:1]};
    if (i_div) begin
      // Partial remainder stays below the divisor, so bit DATA_W of the difference is the borrow.
      if (!w_diff[DATA_W]) begin
        o_acc_hi = w_diff[DATA_W-1:0];
        o_acc_lo = {i_acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        o_acc_hi = w_shift[DATA_W-1:0];
        o_acc_lo = {i_acc_lo[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_alu_hilo_unit.sv
// ============================================================================
// mips_alu_hilo_unit : HI/LO owner with iterative multiply/divide and mthi/mtlo.
// Optional macro MIPS_ALU_HILO_FAST_MUL_EN: single-cycle multiply.
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_alu_hilo_unit
  import mips_alu_hilo_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  mips_alu_func_t    func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi
);

  hilo_state_t         r_state;
  hilo_state_t         w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc_hi;
  logic [DATA_W-1:0]   r_acc_lo;
  logic [DATA_W-1:0]   r_opnd;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_done;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_hi;

  logic                w_accept;
  logic                w_start_iter;
  logic                w_fix_write;
  logic                w_signed;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W-1:0]   w_step_hi;
  logic [DATA_W-1:0]   w_step_lo;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_res_lo;
  logic [DATA_W-1:0]   w_res_hi;

`ifdef MIPS_ALU_HILO_FAST_MUL_EN
  logic signed [DATA_W:0]     w_fa;
  logic signed [DATA_W:0]     w_fb;
  logic signed [2*DATA_W+1:0] w_fprod;

  // One extra sign/zero bit lets a single signed multiplier serve both flavours.
  always_comb begin
    w_fa    = {w_signed & data1[DATA_W-1], data1};
    w_fb    = {w_signed & data2[DATA_W-1], data2};
    w_fprod = w_fa * w_fb;
  end
`endif

  always_comb begin
    w_accept = start && (r_state == ST_IDLE) && (is_mul(func) || is_div(func) || is_mt(func));
`ifdef MIPS_ALU_HILO_FAST_MUL_EN
    w_start_iter = w_accept && is_div(func);
`else
    w_start_iter = w_accept && (is_mul(func) || is_div(func));
`endif
    w_fix_write = (r_state == ST_FIX) && !cancel;
    w_signed    = is_signed_op(func);
    w_abs1      = (w_signed && data1[DATA_W-1]) ? -data1 : data1;
    w_abs2      = (w_signed && data2[DATA_W-1]) ? -data2 : data2;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_iter) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (cancel)                       w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(1))      w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  mips_alu_hilo_unit_step #(.DATA_W(DATA_W)) u_step (
    .i_div    (r_is_div),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_opnd   (r_opnd),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  // Magnitude result is sign-corrected on the way into HI/LO.
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_neg_q) w_prod = -w_prod;
    if (r_is_div) begin
      w_res_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
      w_res_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
    end else begin
      w_res_lo = w_prod[DATA_W-1:0];
      w_res_hi = w_prod[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_iter) begin
        r_cnt    <= CNT_W'(DATA_W);
        r_is_div <= is_div(func);
        r_acc_hi <= '0;
        r_acc_lo <= is_div(func) ? w_abs1 : w_abs2;
        r_opnd   <= is_div(func) ? w_abs2 : w_abs1;
        r_neg_q  <= w_signed && (data1[DATA_W-1] ^ data2[DATA_W-1]);
        r_neg_r  <= w_signed && data1[DATA_W-1];
      end else if ((r_state == ST_RUN) && !cancel) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        r_cnt    <= r_cnt - CNT_W'(1);
      end
      if (w_accept && (func == FUNC_MTHI)) begin
        r_hi   <= data1;
        r_done <= 1'b1;
      end
      if (w_accept && (func == FUNC_MTLO)) begin
        r_lo   <= data1;
        r_done <= 1'b1;
      end
`ifdef MIPS_ALU_HILO_FAST_MUL_EN
      if (w_accept && is_mul(func)) begin
        r_lo   <= w_fprod[DATA_W-1:0];
        r_hi   <= w_fprod[2*DATA_W-1:DATA_W];
        r_done <= 1'b1;
      end
`endif
      if (w_fix_write) begin
        r_lo   <= w_res_lo;
        r_hi   <= w_res_hi;
        r_done <= 1'b1;
      end
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign reg_lo = r_lo;
  assign reg_hi = r_hi;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_hilo_unit.sv
// ============================================================================
// tb_mips_alu_hilo_unit : directed vector table plus cancel/reset sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_alu_hilo_unit;
  import mips_alu_hilo_unit_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  mips_alu_func_t func;
  logic [31:0]    data1;
  logic [31:0]    data2;
  logic           cancel;
  logic           busy;
  logic           done;
  logic [31:0]    reg_lo;
  logic [31:0]    reg_hi;

  int checks = 0;
  int failures = 0;

  typedef struct {
    mips_alu_func_t f;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    lo;
    logic [31:0]    hi;
  } vec_t;

  vec_t vt[14];

  mips_alu_hilo_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .data1  (data1),
    .data2  (data2),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .reg_lo (reg_lo),
    .reg_hi (reg_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_busy(input mips_alu_func_t f);
    if (is_mt(f)) return 0;
`ifdef MIPS_ALU_HILO_FAST_MUL_EN
    if (is_mul(f)) return 0;
`endif
    return 33;
  endfunction

  task automatic do_op(input string nm, input mips_alu_func_t f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi);
    int busy_n = 0;
    int t = 0;
    @(negedge clk);
    start = 1'b1; func = f; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      t++;
    end
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'(exp_busy(f)));
    chk({nm, " lo"}, 64'(reg_lo), 64'(elo));
    chk({nm, " hi"}, 64'(reg_hi), 64'(ehi));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vt[0]  = '{FUNC_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vt[1]  = '{FUNC_MULS, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vt[2]  = '{FUNC_DIVS, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vt[3]  = '{FUNC_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vt[4]  = '{FUNC_DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005};
    vt[5]  = '{FUNC_DIVS, 32'hFFFFFFFB, 32'h00000000, 32'h00000001, 32'hFFFFFFFB};
    vt[6]  = '{FUNC_DIVU, 32'd100,      32'd7,        32'd14,       32'd2};
    vt[7]  = '{FUNC_MULS, 32'h12345678, 32'h00000002, 32'h2468ACF0, 32'h00000000};
    vt[8]  = '{FUNC_MULU, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001};
    vt[9]  = '{FUNC_MULS, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    vt[10] = '{FUNC_DIVS, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    vt[11] = '{FUNC_DIVU, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 32'h00000001};
    vt[12] = '{FUNC_MTHI, 32'hCAFEF00D, 32'h0,        32'h7FFFFFFF, 32'hCAFEF00D};
    vt[13] = '{FUNC_MTLO, 32'h0BADC0DE, 32'h0,        32'h0BADC0DE, 32'hCAFEF00D};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; func = FUNC_ADD; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset lo", 64'(reg_lo), 64'd0);
    chk("reset hi", 64'(reg_hi), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      do_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].lo, vt[i].hi);

    // Non-HI/LO function codes must be ignored.
    begin
      int seen = 0;
      @(negedge clk);
      start = 1'b1; func = FUNC_ADD; data1 = 32'h1111; data2 = 32'h2222;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (done || busy) seen++;
        @(negedge clk);
      end
      chk("ignored_func activity", 64'(seen), 64'd0);
      chk("ignored_func lo", 64'(reg_lo), 64'h0BADC0DE);
    end

    do_op("mthi1234", FUNC_MTHI, 32'h1234, 32'h0, 32'h0BADC0DE, 32'h1234);
    do_op("mtlo1234", FUNC_MTLO, 32'h1234, 32'h0, 32'h1234, 32'h1234);

    // Cancel mid-divide, with a stray start while busy.
    begin
      int seen = 0;
      int bad_busy = 0;
      @(negedge clk);
      start = 1'b1; func = FUNC_DIVU; data1 = 32'd100; data2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        if (!busy) bad_busy++;
        if (reg_lo != 32'h1234 || reg_hi != 32'h1234) seen++;
        start = (c == 3); func = FUNC_MTLO; data1 = 32'hFFFF;
        cancel = (c == 10);
        @(negedge clk);
      end
      start = 1'b0; cancel = 1'b0;
      chk("cancel busy_during", 64'(bad_busy), 64'd0);
      chk("cancel hilo_stable", 64'(seen), 64'd0);
      chk("cancel busy_after", 64'(busy), 64'd0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) seen++;
        @(negedge clk);
      end
      chk("cancel no_done", 64'(seen), 64'd0);
      chk("cancel lo", 64'(reg_lo), 64'h1234);
      chk("cancel hi", 64'(reg_hi), 64'h1234);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; func = FUNC_DIVU; data1 = 32'd1000; data2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("prereset busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", 64'(busy), 64'd0);
    chk("async_rst lo", 64'(reg_lo), 64'd0);
    chk("async_rst hi", 64'(reg_hi), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst mtlo", FUNC_MTLO, 32'h55, 32'h0, 32'h55, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
